reg_file_amisha: RTL and testbench



---
 rtl/reg_file_pkg.sv | 15 +
 rtl/reg_file_wdec.sv | 26 ++
 rtl/reg_file_amisha.sv | 61 ++++++
 tb/tb_reg_file_amisha.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared configuration for the scratch register file: default geometry and
// the depth derivation used by the decoder and the storage array.
package reg_file_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 2;

  // Depth is always an exact power of two, so every address is in range.
  function automatic int depth_f(input int addr_width);
    return 32'sd1 << addr_width;
  endfunction

  localparam int DEPTH = depth_f(ADDR_WIDTH_DEF);

endpackage

// File: rtl/reg_file_wdec.sv
// One-hot write-enable decoder: turns a write address plus global enable into
// one enable per stored word.
module reg_file_wdec
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  localparam int DEPTH_L   = depth_f(ADDR_WIDTH)
) (
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] w_addr_i,
  output logic [DEPTH_L-1:0]    word_we_o
);

  // At most one bit is set, and none when the write is disabled.
  always_comb begin
    word_we_o = '0;
    for (int i = 0; i < DEPTH_L; i++) begin
      if (wr_en_i && (w_addr_i == ADDR_WIDTH'(i))) begin
        word_we_o[i] = 1'b1;
      end else begin
        word_we_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_file_amisha.sv
// Register file: one synchronous write port, one combinational read port,
// all words cleared asynchronously by rst_n_amisha.
module reg_file_amisha
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk_amisha,
  input  logic                  rst_n_amisha,
  input  logic                  wr_en_amisha,
  input  logic [ADDR_WIDTH-1:0] w_addr_amisha,
  input  logic [ADDR_WIDTH-1:0] r_addr_amisha,
  input  logic [DATA_WIDTH-1:0] w_data_amisha,
  output logic [DATA_WIDTH-1:0] r_data_amisha
);

  localparam int DEPTH_L = depth_f(ADDR_WIDTH);

  logic [DEPTH_L-1:0]    word_we;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH_L];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH_L];

  reg_file_wdec #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wdec (
    .wr_en_i   (wr_en_amisha),
    .w_addr_i  (w_addr_amisha),
    .word_we_o (word_we)
  );

  // Next-state: only the decoded word takes the write data.
  always_comb begin
    for (int i = 0; i < DEPTH_L; i++) begin
      if (word_we[i]) begin
        mem_d[i] = w_data_amisha;
      end else begin
        mem_d[i] = mem_q[i];
      end
    end
  end

  // Storage array; the asynchronous clear overrides any write in flight.
  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      for (int i = 0; i < DEPTH_L; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH_L; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Zero-latency read with no bypass: a same-cycle write shows only after the edge.
  always_comb begin
    r_data_amisha = mem_q[r_addr_amisha];
  end

endmodule

// File: tb/tb_reg_file_amisha.sv
// Directed plus randomized bench for reg_file_amisha, checked against a plain
// array model of the storage contents.
module tb_reg_file_amisha;
  import reg_file_pkg::*;

  localparam int DW = DATA_WIDTH_DEF;
  localparam int AW = ADDR_WIDTH_DEF;

  logic          clk_amisha;
  logic          rst_n_amisha;
  logic          wr_en_amisha;
  logic [AW-1:0] w_addr_amisha;
  logic [AW-1:0] r_addr_amisha;
  logic [DW-1:0] w_data_amisha;
  logic [DW-1:0] r_data_amisha;

  logic [DW-1:0] model [DEPTH];
  int checks;
  int failures;

  reg_file_amisha #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk_amisha    (clk_amisha),
    .rst_n_amisha  (rst_n_amisha),
    .wr_en_amisha  (wr_en_amisha),
    .w_addr_amisha (w_addr_amisha),
    .r_addr_amisha (r_addr_amisha),
    .w_data_amisha (w_data_amisha),
    .r_data_amisha (r_data_amisha)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic read_check(input string tag, input int a, input logic [DW-1:0] exp);
    r_addr_amisha = AW'(a);
    #1;
    check(tag, r_data_amisha, exp);
  endtask

  // One full clock period; the model follows the write rule at the rising edge.
  task automatic tick();
    #4;
    clk_amisha = 1'b1;
    if (rst_n_amisha && wr_en_amisha) model[int'(w_addr_amisha)] = w_data_amisha;
    #5;
    clk_amisha = 1'b0;
    #1;
  endtask

  task automatic write_word(input int a, input int d);
    wr_en_amisha  = 1'b1;
    w_addr_amisha = AW'(a);
    w_data_amisha = DW'(d);
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clk_amisha = 1'b0;
    rst_n_amisha = 1'b0;
    wr_en_amisha = 1'b0;
    w_addr_amisha = '0;
    r_addr_amisha = '0;
    w_data_amisha = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    #2;

    // Reset sweep
    for (int i = 0; i < DEPTH; i++) read_check("reset_read", i, 8'd0);
    rst_n_amisha = 1'b1;
    #2;

    // Fill and read back out of order
    write_word(0, 2);
    write_word(1, 7);
    write_word(2, 11);
    write_word(3, 16);
    wr_en_amisha = 1'b0;
    read_check("fill_a2", 2, 8'd11);
    read_check("fill_a1", 1, 8'd7);
    read_check("fill_a3", 3, 8'd16);
    read_check("fill_a0", 0, 8'd2);

    // Disabled write leaves the word alone
    wr_en_amisha = 1'b0;
    w_addr_amisha = 2'd1;
    w_data_amisha = 8'hFF;
    tick();
    read_check("wr_disabled", 1, 8'd7);

    // Combinational read with clock held high
    r_addr_amisha = 2'd2;
    #1;
    clk_amisha = 1'b1;
    #2;
    check("comb_before", r_data_amisha, 8'd11);
    r_addr_amisha = 2'd3;
    #1;
    check("comb_after", r_data_amisha, 8'd16);
    #2;
    clk_amisha = 1'b0;
    #3;

    // Same-address read/write collision
    r_addr_amisha = 2'd0;
    w_addr_amisha = 2'd0;
    w_data_amisha = 8'h5A;
    wr_en_amisha = 1'b1;
    #1;
    check("collide_pre", r_data_amisha, 8'd2);
    tick();
    check("collide_post", r_data_amisha, 8'h5A);

    // Static clock: input activity must not change contents
    for (int i = 0; i < DEPTH; i++) begin
      wr_en_amisha = 1'b1;
      w_addr_amisha = AW'(i);
      w_data_amisha = DW'($urandom_range(0, 255));
      #2;
    end
    wr_en_amisha = 1'b0;
    read_check("static_a0", 0, 8'h5A);
    read_check("static_a1", 1, 8'd7);
    read_check("static_a2", 2, 8'd11);
    read_check("static_a3", 3, 8'd16);

    // Randomized traffic against the model
    for (int n = 0; n < 200; n++) begin
      wr_en_amisha = 1'($urandom_range(0, 1));
      w_addr_amisha = AW'($urandom_range(0, DEPTH - 1));
      w_data_amisha = DW'($urandom_range(0, 255));
      r_addr_amisha = AW'($urandom_range(0, DEPTH - 1));
      #1;
      check("rand_pre", r_data_amisha, model[int'(r_addr_amisha)]);
      tick();
      check("rand_post", r_data_amisha, model[int'(r_addr_amisha)]);
    end

    // Asynchronous reset between edges, with a write pending
    wr_en_amisha = 1'b1;
    w_addr_amisha = 2'd1;
    w_data_amisha = 8'h33;
    #2;
    rst_n_amisha = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int i = 0; i < DEPTH; i++) read_check("async_rst", i, 8'd0);
    tick();
    read_check("rst_priority", 1, 8'd0);
    rst_n_amisha = 1'b1;
    #2;
    tick();
    read_check("first_write_after_rst", 1, 8'h33);
    read_check("other_word_after_rst", 2, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
